kaipokrandt_mem_ctrl: RTL and testbench

- Memory unit directly downstream of the memory address register; consumes its 16-bit registered address output as `addr_in`.
- Owns a word-addressed on-chip RAM.
- Sequences single read/write transactions through a configurable wait-state FSM with a busy/done handshake to the control unit.
- Read data is returned on a registered output for the memory data register to load.

---
 rtl/kaipokrandt_pkg.sv | 12 +
 rtl/kaipokrandt_ram_array.sv | 21 ++
 rtl/kaipokrandt_mem_ctrl.sv | 102 ++++++++++
 tb/tb_kaipokrandt_mem_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/kaipokrandt_pkg.sv
// kaipokrandt_pkg: shared types and constants for the memory controller slice.
package kaipokrandt_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    // Out-of-range reads return this pattern, truncated to the data width.
    localparam logic [63:0] RD_FILL = '1;

endpackage

// File: rtl/kaipokrandt_ram_array.sv
// kaipokrandt_ram_array: word-addressed RAM with synchronous write and registered read.
module kaipokrandt_ram_array #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [1 << DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/kaipokrandt_mem_ctrl.sv
// kaipokrandt_mem_ctrl: sequences single RAM reads/writes through a wait-state FSM
// with a busy/done handshake; out-of-range addresses are flagged and never touch RAM.
module kaipokrandt_mem_ctrl
    import kaipokrandt_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              addr_err
);

    state_t            state, state_nx;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] ram_q;
    logic              op_wr;
    logic              rd_valid;
    logic              rd_oor;
    logic              oor;
    logic              commit;
    logic              accept;

    assign oor    = (addr_q >> DEPTH_LOG2) != '0;
    assign accept = (state == IDLE) && (rd_req || wr_req);

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        addr_err = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE:    if (accept) state_nx = ACCESS;
            ACCESS: begin
                busy   = 1'b1;
                commit = (cnt == 4'd0);
                if (commit) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                addr_err = oor;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            addr_q   <= '0;
            data_q   <= '0;
            op_wr    <= 1'b0;
            rd_valid <= 1'b0;
            rd_oor   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q <= addr_in;
                data_q <= wr_data;
                op_wr  <= wr_req;
                cnt    <= 4'(WAIT_STATES);
            end else if (state == ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit && !op_wr) begin
                rd_valid <= 1'b1;
                rd_oor   <= oor;
            end
        end
    end

    kaipokrandt_ram_array #(
        .DATA_W    (DATA_W),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk  (clk),
        .we   (commit && op_wr && !oor),
        .re   (commit && !op_wr && !oor),
        .addr (addr_q[DEPTH_LOG2-1:0]),
        .wdata(data_q),
        .rdata(ram_q)
    );

    // The RAM output register holds the last in-range read; reset and
    // out-of-range reads are overlaid here so the storage needs no reset.
    assign rd_data = !rd_valid ? '0 : rd_oor ? RD_FILL[DATA_W-1:0] : ram_q;

endmodule

// File: tb/tb_kaipokrandt_mem_ctrl.sv
// tb_kaipokrandt_mem_ctrl: directed self-checking bench for the memory controller.
module tb_kaipokrandt_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr_in;
    logic        rd_req;
    logic        wr_req;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic        addr_err;

    int          errors = 0;
    int          checks = 0;

    int          obs_busy;
    int          obs_done_at;
    logic        obs_err;
    logic [15:0] obs_rd;
    logic        obs_done_after;

    kaipokrandt_mem_ctrl #(
        .ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(8), .WAIT_STATES(2)
    ) dut (
        .clk(clk), .reset(reset), .addr_in(addr_in), .rd_req(rd_req),
        .wr_req(wr_req), .wr_data(wr_data), .rd_data(rd_data),
        .busy(busy), .done(done), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    // Presents one request for a single edge, then drives a2/d2 while the
    // transaction is in flight and records what the handshake looked like.
    task automatic run_txn(input logic w, input logic r, input logic [15:0] a,
                           input logic [15:0] d, input logic [15:0] a2, input logic [15:0] d2);
        @(negedge clk);
        wr_req = w; rd_req = r; addr_in = a; wr_data = d;
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b0; addr_in = a2; wr_data = d2;
        obs_busy = 0; obs_done_at = -1; obs_err = 1'bx; obs_rd = 'x;
        for (int i = 1; i <= 20; i++) begin
            if (busy) obs_busy++;
            if (done) begin
                obs_done_at = i; obs_err = addr_err; obs_rd = rd_data;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        obs_done_after = done;
    endtask

    task automatic test_reset;
        reset = 1'b0; addr_in = 0; rd_req = 0; wr_req = 0; wr_data = 0;
        #12;
        checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL rst_rd_data got=%h exp=0000", rd_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL rst_addr_err got=%b exp=0", addr_err); end
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL post_rst_rd_data got=%h exp=0000", rd_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL post_rst_done got=%b exp=0", done); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL post_rst_addr_err got=%b exp=0", addr_err); end
    endtask

    task automatic test_write_read;
        run_txn(1, 0, 16'h0012, 16'hBEEF, 16'h0012, 16'hBEEF);
        checks++; if (obs_busy !== 3) begin errors++; $display("FAIL wr_busy_cycles got=%0d exp=3", obs_busy); end
        checks++; if (obs_done_at !== 4) begin errors++; $display("FAIL wr_done_cycle got=%0d exp=4", obs_done_at); end
        checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL wr_addr_err got=%b exp=0", obs_err); end
        checks++; if (obs_done_after !== 1'b0) begin errors++; $display("FAIL wr_done_width got=%b exp=0", obs_done_after); end
        checks++; if (obs_rd !== 16'h0000) begin errors++; $display("FAIL wr_rd_data_kept got=%h exp=0000", obs_rd); end
        run_txn(0, 1, 16'h0012, 16'h0000, 16'h0000, 16'h0000);
        checks++; if (obs_busy !== 3) begin errors++; $display("FAIL rd_busy_cycles got=%0d exp=3", obs_busy); end
        checks++; if (obs_done_at !== 4) begin errors++; $display("FAIL rd_done_cycle got=%0d exp=4", obs_done_at); end
        checks++; if (obs_rd !== 16'hBEEF) begin errors++; $display("FAIL rd_data got=%h exp=beef", obs_rd); end
        checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL rd_addr_err got=%b exp=0", obs_err); end
        checks++; if (rd_data !== 16'hBEEF) begin errors++; $display("FAIL rd_data_hold got=%h exp=beef", rd_data); end
    endtask

    task automatic test_out_of_range;
        run_txn(1, 0, 16'h0000, 16'h1111, 16'h0000, 16'h0000);
        run_txn(0, 1, 16'h0100, 16'h0000, 16'h0000, 16'h0000);
        checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL oor_rd_err got=%b exp=1", obs_err); end
        checks++; if (obs_rd !== 16'hFFFF) begin errors++; $display("FAIL oor_rd_data got=%h exp=ffff", obs_rd); end
        run_txn(1, 0, 16'h0100, 16'h2222, 16'h0000, 16'h0000);
        checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL oor_wr_err got=%b exp=1", obs_err); end
        checks++; if (obs_rd !== 16'hFFFF) begin errors++; $display("FAIL oor_wr_rd_kept got=%h exp=ffff", obs_rd); end
        run_txn(0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        checks++; if (obs_rd !== 16'h1111) begin errors++; $display("FAIL ram0_intact got=%h exp=1111", obs_rd); end
        checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL ram0_err got=%b exp=0", obs_err); end
    endtask

    task automatic test_write_priority;
        run_txn(1, 1, 16'h0005, 16'h1234, 16'h0005, 16'h1234);
        checks++; if (obs_rd !== 16'h1111) begin errors++; $display("FAIL both_rd_kept got=%h exp=1111", obs_rd); end
        checks++; if (obs_done_at !== 4) begin errors++; $display("FAIL both_done_cycle got=%0d exp=4", obs_done_at); end
        run_txn(0, 1, 16'h0005, 16'h0000, 16'h0000, 16'h0000);
        checks++; if (obs_rd !== 16'h1234) begin errors++; $display("FAIL both_readback got=%h exp=1234", obs_rd); end
    endtask

    task automatic test_inflight_change;
        run_txn(1, 0, 16'h0004, 16'h4444, 16'h0004, 16'h4444);
        run_txn(1, 0, 16'h0003, 16'hAAAA, 16'h0004, 16'h5555);
        run_txn(0, 1, 16'h0003, 16'h0000, 16'h0000, 16'h0000);
        checks++; if (obs_rd !== 16'hAAAA) begin errors++; $display("FAIL inflight_ram3 got=%h exp=aaaa", obs_rd); end
        run_txn(0, 1, 16'h0004, 16'h0000, 16'h0000, 16'h0000);
        checks++; if (obs_rd !== 16'h4444) begin errors++; $display("FAIL inflight_ram4 got=%h exp=4444", obs_rd); end
    endtask

    task automatic test_reset_abort;
        int pulses;
        run_txn(1, 0, 16'h0020, 16'h6666, 16'h0020, 16'h6666);
        @(negedge clk);
        wr_req = 1'b1; addr_in = 16'h0020; wr_data = 16'h7777;
        @(negedge clk);
        wr_req = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy got=%b exp=1", busy); end
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
        pulses = 0;
        repeat (2) @(posedge clk) #1 pulses += int'(done);
        @(negedge clk); reset = 1'b1;
        repeat (5) @(posedge clk) #1 pulses += int'(done);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", pulses); end
        run_txn(0, 1, 16'h0020, 16'h0000, 16'h0000, 16'h0000);
        checks++; if (obs_rd !== 16'h6666) begin errors++; $display("FAIL abort_ram20 got=%h exp=6666", obs_rd); end
    endtask

    task automatic test_back_to_back;
        logic [5:0] b, d;
        @(negedge clk);
        rd_req = 1'b1; addr_in = 16'h0012;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            b[i] = busy; d[i] = done;
        end
        rd_req = 1'b0;
        checks++; if (b !== 6'b100111) begin errors++; $display("FAIL b2b_busy got=%b exp=100111", b); end
        checks++; if (d !== 6'b001000) begin errors++; $display("FAIL b2b_done got=%b exp=001000", d); end
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_done got=%b exp=1", done); end
        checks++; if (rd_data !== 16'hBEEF) begin errors++; $display("FAIL b2b_rd_data got=%h exp=beef", rd_data); end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_out_of_range;
        test_write_priority;
        test_inflight_change;
        test_reset_abort;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
